// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nsa_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the nibble index for a given operand width.
  function automatic int unsigned idx_width(input int unsigned width);
    return $clog2(width / NIB_W);
  endfunction

endpackage

// File: rtl/nibble_serial_adder_rca4.sv
// Combinational 4-bit ripple-carry adder used as the per-nibble slice.
module nibble_serial_adder_rca4
  import nsa_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             cout
);

  logic [NIB_W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < NIB_W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    cout = c[NIB_W];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Adds or subtracts two WIDTH-bit operands one nibble per cycle through a
// single 4-bit ripple slice, with valid/ready handshakes on both sides.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V
);

  localparam int unsigned NIBS  = WIDTH / NIB_W;
  localparam int unsigned IDX_W = idx_width(WIDTH);
  localparam int unsigned MSB   = WIDTH - 1;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   bx_q;
  logic               carry;
  logic [WIDTH-1:0]   s_q;
  logic               cout_q;
  logic               v_q;

  logic [NIB_W-1:0]   a_nib;
  logic [NIB_W-1:0]   b_nib;
  logic [NIB_W-1:0]   slice_s;
  logic               slice_cout;
  logic               last_nib;

  // Select the operand nibbles addressed by the current index.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int unsigned i = 0; i < NIBS; i++) begin
      if (idx == IDX_W'(i)) begin
        a_nib = a_q[i*NIB_W +: NIB_W];
        b_nib = bx_q[i*NIB_W +: NIB_W];
      end
    end
  end

  assign last_nib = (idx == IDX_W'(NIBS - 1));

  nibble_serial_adder_rca4 u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry),
    .s    (slice_s),
    .cout (slice_cout)
  );

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      a_q    <= '0;
      bx_q   <= '0;
      carry  <= 1'b0;
      s_q    <= '0;
      cout_q <= 1'b0;
      v_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= A;
            bx_q  <= sub ? ~B : B;
            carry <= sub ? 1'b1 : Cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          for (int unsigned i = 0; i < NIBS; i++) begin
            if (idx == IDX_W'(i)) begin
              s_q[i*NIB_W +: NIB_W] <= slice_s;
            end
          end
          carry <= slice_cout;
          if (last_nib) begin
            // Top slice sum bit is the result MSB; overflow uses the inverted B for subtraction.
            cout_q <= slice_cout;
            v_q    <= (a_q[MSB] == bx_q[MSB]) && (slice_s[NIB_W-1] != a_q[MSB]);
            idx    <= '0;
            state  <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign S         = s_q;
  assign Cout      = cout_q;
  assign V         = v_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder against a plain-arithmetic model.
module tb_nibble_serial_adder;

  localparam int unsigned W    = 16;
  localparam int unsigned NIBS = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] S;
  logic         Cout;
  logic         V;

  int n_checks = 0;
  int n_fail   = 0;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .Cout      (Cout),
    .V         (V)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Reference: {Cout, V, S} from integer arithmetic on the operands.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sb);
    longint sa, sbv, r, full;
    logic [W-1:0] s;
    logic co, ov;
    sa   = longint'($signed(a));
    sbv  = longint'($signed(b));
    if (sb) begin
      full = longint'(a) - longint'(b);
      co   = (a >= b);
      r    = sa - sbv;
    end else begin
      full = longint'(a) + longint'(b) + longint'(cin);
      co   = (full >= (longint'(1) << W));
      r    = sa + sbv + longint'(cin);
    end
    s  = W'(full);
    ov = (r > ((longint'(1) << (W-1)) - 1)) || (r < -(longint'(1) << (W-1)));
    return {co, ov, s};
  endfunction

  // Drives one operation and returns the result seen when out_valid rises.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sb, input int hold,
                        output logic [W-1:0] s, output logic co, output logic ov,
                        output int lat);
    int g;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    A = a; B = b; Cin = cin; sub = sb; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    A = W'($urandom); B = W'($urandom); Cin = 1'($urandom); sub = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
    s = S; co = Cout; ov = V;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    A = 16'h1234; B = 16'h4321; Cin = 1'b1; sub = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL reset_hs: in_ready/out_valid=%b required 10", {in_ready, out_valid});
    end
    n_checks++;
    if ({Cout, V, S} !== {2'b00, 16'h0000}) begin
      n_fail++; $display("FAIL reset_out: S=%h Cout=%b V=%b required 0000 0 0", S, Cout, V);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL idle_hold: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input logic sb, input logic [W+1:0] want);
    logic [W-1:0] s; logic co, ov; int lat;
    run_op(a, b, cin, sb, 0, s, co, ov, lat);
    n_checks++;
    if (lat !== int'(NIBS)) begin
      n_fail++; $display("FAIL %s_latency: got %0d required %0d", name, lat, NIBS);
    end
    n_checks++;
    if ({co, ov, s} !== want) begin
      n_fail++; $display("FAIL %s_result: got S=%h Cout=%b V=%b required S=%h Cout=%b V=%b",
                         name, s, co, ov, want[W-1:0], want[W+1], want[W]);
    end
    n_checks++;
    if ({want !== model(a, b, cin, sb)}) begin
      n_fail++; $display("FAIL %s_model: model=%h required %h", name, model(a, b, cin, sb), want);
    end
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s_release: out_valid=%b in_ready=%b required 0 1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure;
    logic [W+1:0] exp;
    int g;
    exp = model(16'h1A2B, 16'h3C4D, 1'b1, 1'b0);
    @(negedge clk);
    A = 16'h1A2B; B = 16'h3C4D; Cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    g = 0;
    while (!out_valid && g < 20) begin @(negedge clk); g++; end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({Cout, V, S} !== exp || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold%0d: S=%h Cout=%b V=%b rdy=%b vld=%b required S=%h Cout=%b V=%b 0 1",
                           i, S, Cout, V, in_ready, out_valid, exp[W-1:0], exp[W+1], exp[W]);
      end
      in_valid = (i % 2 == 0);
      A = W'($urandom); B = W'($urandom); sub = 1'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || {Cout, V, S} !== exp) begin
      n_fail++; $display("FAIL bp_release: vld=%b rdy=%b S=%h required 0 1 %h", out_valid, in_ready, S, exp[W-1:0]);
    end
  endtask

  task automatic test_reset_mid_run;
    bit seen;
    @(negedge clk);
    A = 16'hFFFF; B = 16'h0F0F; Cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || {Cout, V, S} !== {2'b00, 16'h0000}) begin
      n_fail++; $display("FAIL rst_run: rdy=%b vld=%b S=%h required 1 0 0000", in_ready, out_valid, S);
    end
    seen = 1'b0;
    repeat (10) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL rst_no_valid: out_valid pulse seen=%b required 0", seen);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] a1, b1, a2, b2;
    logic [W+1:0] r1, r2, e1, e2;
    int t1, t2, nres;
    a1 = W'($urandom); b1 = W'($urandom); a2 = W'($urandom); b2 = W'($urandom);
    e1 = model(a1, b1, 1'b0, 1'b1);
    e2 = model(a2, b2, 1'b1, 1'b0);
    r1 = '0; r2 = '0;
    t1 = -1; t2 = -1; nres = 0;
    @(negedge clk);
    A = a1; B = b1; Cin = 1'b0; sub = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 40 && nres < 2; c++) begin
      if (in_valid && in_ready) begin
        if (t1 < 0) t1 = c; else if (t2 < 0) t2 = c;
      end
      if (out_valid && out_ready) begin
        if (nres == 0) r1 = {Cout, V, S}; else r2 = {Cout, V, S};
        nres++;
      end
      @(negedge clk);
      if (t1 >= 0) begin A = a2; B = b2; Cin = 1'b1; sub = 1'b0; end
      if (t2 >= 0) in_valid = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++;
    if (t2 - t1 !== 6 || t1 < 0 || t2 < 0) begin
      n_fail++; $display("FAIL b2b_period: accepts at %0d and %0d required period 6", t1, t2);
    end
    n_checks++;
    if (r1 !== e1) begin
      n_fail++; $display("FAIL b2b_first: got %h required %h", r1, e1);
    end
    n_checks++;
    if (r2 !== e2) begin
      n_fail++; $display("FAIL b2b_second: got %h required %h", r2, e2);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, s; logic cin, sb, co, ov; int lat;
    logic [W+1:0] exp;
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sb = 1'($urandom);
      if (i % 8 == 0) a = 16'h8000;
      if (i % 8 == 1) b = 16'h8000;
      if (i % 8 == 2) b = a;
      exp = model(a, b, cin, sb);
      run_op(a, b, cin, sb, int'($urandom_range(0, 3)), s, co, ov, lat);
      n_checks++;
      if (lat !== int'(NIBS) || {co, ov, s} !== exp) begin
        n_fail++; $display("FAIL rand%0d: A=%h B=%h cin=%b sub=%b got lat=%0d S=%h Cout=%b V=%b required lat=%0d S=%h Cout=%b V=%b",
                           i, a, b, cin, sb, lat, s, co, ov, NIBS, exp[W-1:0], exp[W+1], exp[W]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; Cin = 1'b0; sub = 1'b0;
    test_reset();
    test_directed("carry_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {2'b10, 16'h0000});
    test_directed("overflow",     16'h7FFF, 16'h0001, 1'b0, 1'b0, {2'b01, 16'h8000});
    test_directed("subtract",     16'h0005, 16'h0007, 1'b1, 1'b1, {2'b00, 16'hFFFE});
    test_directed("sub_equal",    16'h1234, 16'h1234, 1'b0, 1'b1, {2'b10, 16'h0000});
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width; SHALL be a multiple of 4 and at least 8.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  operand transfer request.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 A  input  WIDTH  operand A.
REQ-007 B  input  WIDTH  operand B.
REQ-008 Cin  input  1  carry-in; used only when sub=0.
REQ-009 sub  input  1  1 = compute A-B, 0 = compute A+B+Cin.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 S  output  WIDTH  registered sum/difference.
REQ-013 Cout  output  1  registered carry out of bit WIDTH-1.
REQ-014 V  output  1  registered two's-complement overflow flag.

Function
REQ-015 FSM states: IDLE, RUN, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-016 IDLE: an input handshake occurs when in_valid=1.
  - Captures A, Bx=(sub ? ~B : B), carry=(sub ? 1 : Cin).
  - Clears the nibble index to 0.
  - Moves to RUN.
REQ-017 IDLE with in_valid=0: state held.
REQ-018 RUN, per cycle: one 4-bit slice adds nibble[idx] of A and Bx with the carry register.
  - Writes the 4-bit result into S nibble[idx].
  - Loads the slice carry-out into the carry register.
  - Increments idx.
REQ-019 RUN at idx=WIDTH/4-1: after that nibble, moves to DONE.
  - Cout = final slice carry.
  - V = (A[MSB] == Bx[MSB]) && (S[MSB] != A[MSB]).
REQ-020 Latency: input handshake at edge k gives out_valid=1 after edge k+WIDTH/4 (4 cycles for WIDTH=16); throughput one operation per WIDTH/4+2 cycles.
REQ-021 in_valid, A, B, Cin and sub are ignored in RUN and DONE; captured operands do not change mid-operation.
REQ-022 DONE: S, Cout and V are held stable while out_ready=0, for any duration.
REQ-023 DONE with out_ready=1: output handshake; moves to IDLE on that edge; out_valid deasserts next cycle; S/Cout/V retain their values until the next RUN overwrites them.
REQ-024 No bypass: a new input is not accepted in the same cycle as an output handshake.
REQ-025 The carry chain wraps only across nibbles: carry out of nibble i is carry in of nibble i+1; the carry out of the top nibble goes to Cout, not back into the chain.
REQ-026 S nibbles not yet computed in RUN are don't-care to the consumer; they are observable only while out_valid=0.

Reset
REQ-027 When rst=1 at a rising edge: state=IDLE, idx=0, carry=0, S=0, Cout=0, V=0, out_valid=0, in_ready=1 from the next cycle.
REQ-028 Reset SHALL override any handshake in the same cycle.
REQ-029 Reset asserted in RUN or DONE aborts the operation; the partial result is discarded and no out_valid pulse is produced.

Structure
REQ-030 Shared package nsa_pkg holds:
  - State enum {IDLE, RUN, DONE}.
  - NIB_W=4.
  - Function computing the index width, clog2(WIDTH/4).
REQ-031 Exactly one sub-module: the team's existing combinational 4-bit ripple adder (A, B, Cin -> S, Cout), instantiated once as the per-nibble slice; no other arithmetic operators on the datapath.
REQ-032 All outputs driven from registers; in_ready and out_valid decoded from the state register only.

Verification
REQ-033 Carry ripple: A=0xFFFF, B=0x0001, Cin=0, sub=0 -> 4 cycles later out_valid=1, S=0x0000, Cout=1, V=0.
REQ-034 Signed overflow: A=0x7FFF, B=0x0001, Cin=0, sub=0 -> S=0x8000, Cout=0, V=1.
REQ-035 Subtract: A=0x0005, B=0x0007, sub=1, Cin=1 (ignored) -> S=0xFFFE, Cout=0, V=0.
REQ-036 Backpressure: out_ready=0 for 5 cycles in DONE -> S/Cout/V constant, in_ready=0, in_valid pulses with other operands ignored; out_ready=1 -> IDLE next cycle.
REQ-037 Reset mid-RUN: rst=1 at idx=2 -> next cycle state IDLE, S=0, out_valid never asserted.
REQ-038 Back-to-back: a second operand pair presented with in_valid held high is accepted on the first IDLE cycle after the output handshake; its result is correct and the total period is 6 cycles.
